// File: rtl/sram_pkg.sv
// Shared constants, read FSM states and the analog-to-digital slicing rule
// for the SRAM read path.
package sram_pkg;

    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        WL    = 3'd2,
        SENSE = 3'd3,
        DONE  = 3'd4
    } rd_state_t;

    // NaN fails every ordered comparison, so it always slices to 0
    function automatic logic slice_bit(input real v);
        return (v >= VTH) && (v >= VSS) && (v <= VDD);
    endfunction

endpackage

// File: rtl/sram_read_ctrl_if.sv
// Digital read port between the user logic (master) and the read sequencer (slave).
interface sram_read_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    modport master (output rd_req, rd_addr, input rd_ready, rd_valid, rd_data);
    modport slave  (input rd_req, rd_addr, output rd_ready, rd_valid, rd_data);
endinterface

// File: rtl/sram_row_decoder.sv
// Combinational binary-to-one-hot wordline decoder with enable.
module sram_row_decoder #(
    parameter int ADDR_W = 4
) (
    input  logic                   en_i,
    input  logic [ADDR_W-1:0]      addr_i,
    output logic [2**ADDR_W-1:0]   sel_o
);

    // One-hot select of the addressed row while enabled
    always_comb begin
        sel_o = '0;
        if (en_i) begin
            sel_o[addr_i] = 1'b1;
        end else begin
            sel_o = '0;
        end
    end

endmodule

// File: rtl/sram_read_ctrl.sv
// Read sequencer: precharge, wordline, sense-amp enable, then slice the
// per-column sense-amp voltages into a registered read word.
module sram_read_ctrl
    import sram_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int PRE_CYC = 2,
    parameter int WL_CYC  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_read_ctrl_if.slave      rd,
    output logic                 precharge_en,
    output logic [2**ADDR_W-1:0] wl_sel,
    output logic                 sae,
    input  real                  preout [DATA_W]
);

    localparam int MAX_CYC = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    rd_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [DATA_W-1:0]     slice_s;
    logic                  pre_q, pre_d;
    logic                  sae_q, sae_d;
    logic                  valid_q, valid_d;
    logic                  ready_q, ready_d;
    logic                  wl_en_s;
    logic [2**ADDR_W-1:0]  wl_sel_q, wl_sel_d;

    // Next-state sequencing; the counter holds remaining cycles minus one
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE, DONE: begin
                if (rd.rd_req) begin
                    state_d = PRE;
                    cnt_d   = CNT_W'(PRE_CYC - 1);
                    addr_d  = rd.rd_addr;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            PRE: begin
                if (cnt_q == '0) begin
                    state_d = WL;
                    cnt_d   = CNT_W'(WL_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WL: begin
                if (cnt_q == '0) begin
                    state_d = SENSE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SENSE: begin
                state_d = DONE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Per-column slicing of the sense-amp voltages
    always_comb begin
        slice_s = '0;
        for (int i = 0; i < DATA_W; i++) begin
            slice_s[i] = slice_bit(preout[i]);
        end
    end

    // Outputs are decoded from the next state so every output is a flop
    always_comb begin
        pre_d   = (state_d == PRE);
        wl_en_s = (state_d == WL) || (state_d == SENSE);
        sae_d   = (state_d == SENSE);
        valid_d = (state_d == DONE);
        ready_d = (state_d == IDLE) || (state_d == DONE);
        if (state_q == SENSE) begin
            data_d = slice_s;
        end else begin
            data_d = data_q;
        end
    end

    sram_row_decoder #(.ADDR_W(ADDR_W)) u_row_dec (
        .en_i   (wl_en_s),
        .addr_i (addr_d),
        .sel_o  (wl_sel_d)
    );

    // State and output registers; reset drops the analog controls at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            pre_q    <= 1'b0;
            sae_q    <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            wl_sel_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            pre_q    <= pre_d;
            sae_q    <= sae_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            wl_sel_q <= wl_sel_d;
        end
    end

    assign precharge_en = pre_q;
    assign wl_sel       = wl_sel_q;
    assign sae          = sae_q;
    assign rd.rd_ready  = ready_q;
    assign rd.rd_valid  = valid_q;
    assign rd.rd_data   = data_q;

endmodule

// File: tb/tb_sram_read_ctrl.sv
// Randomized self-checking bench: default-timing and PRE_CYC=WL_CYC=1 instances
// share stimulus and are each compared every cycle against a schedule-based model.
module tb_sram_read_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NR = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_s;
    logic [AW-1:0] addr_s;
    real           preout_s [DW];

    sram_read_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if_a ();
    sram_read_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if_b ();
    assign if_a.rd_req  = req_s;
    assign if_a.rd_addr = addr_s;
    assign if_b.rd_req  = req_s;
    assign if_b.rd_addr = addr_s;

    logic pre_a, sae_a, pre_b, sae_b;
    logic [NR-1:0] wl_a, wl_b;

    sram_read_ctrl #(.DATA_W(DW), .ADDR_W(AW), .PRE_CYC(2), .WL_CYC(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rd(if_a), .precharge_en(pre_a),
        .wl_sel(wl_a), .sae(sae_a), .preout(preout_s));

    sram_read_ctrl #(.DATA_W(DW), .ADDR_W(AW), .PRE_CYC(1), .WL_CYC(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rd(if_b), .precharge_en(pre_b),
        .wl_sel(wl_b), .sae(sae_b), .preout(preout_s));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: a read is an offset k from its acceptance edge
    int            pc [2] = '{2, 1};
    int            wc [2] = '{3, 1};
    bit            busy [2];
    int            k [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_data [2];
    bit            m_ready [2];
    bit            acc [2];
    int            acc_cyc [2];
    int            valid_cyc_a [$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_slice();
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < DW; i++) begin
            if (preout_s[i] == preout_s[i] && preout_s[i] >= 0.8 && preout_s[i] <= 1.5)
                w[i] = 1'b1;
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            busy[i] = 1'b0; k[i] = 0; m_data[i] = '0; m_ready[i] = 1'b1; acc[i] = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic o_pre, o_sae, o_valid, o_ready;
        logic [NR-1:0] o_wl, e_wl;
        logic [DW-1:0] o_data;
        int p, w;
        string nm;
        for (int i = 0; i < 2; i++) begin
            p = pc[i]; w = wc[i];
            nm = (i == 0) ? "A" : "B";
            o_pre   = (i == 0) ? pre_a : pre_b;
            o_sae   = (i == 0) ? sae_a : sae_b;
            o_wl    = (i == 0) ? wl_a : wl_b;
            o_valid = (i == 0) ? if_a.rd_valid : if_b.rd_valid;
            o_ready = (i == 0) ? if_a.rd_ready : if_b.rd_ready;
            o_data  = (i == 0) ? if_a.rd_data : if_b.rd_data;
            e_wl = (busy[i] && k[i] >= p && k[i] <= p + w) ? (NR'(1) << m_addr[i]) : '0;
            check_eq({nm, ".pre"},   o_pre,   busy[i] && k[i] < p);
            check_eq({nm, ".wl"},    o_wl,    e_wl);
            check_eq({nm, ".sae"},   o_sae,   busy[i] && k[i] == p + w);
            check_eq({nm, ".valid"}, o_valid, busy[i] && k[i] == p + w + 1);
            check_eq({nm, ".ready"}, o_ready, m_ready[i]);
            check_eq({nm, ".data"},  o_data,  m_data[i]);
            check_eq({nm, ".inv_pre_wl"}, o_pre & (|o_wl), 1'b0);
            check_eq({nm, ".inv_onehot"}, $onehot0(o_wl), 1'b1);
            check_eq({nm, ".inv_sae_wl"}, o_sae & ~(|o_wl), 1'b0);
            if (o_valid) begin
                check_eq({nm, ".latency"}, cyc - acc_cyc[i] + 1, p + w + 2);
                if (i == 0) valid_cyc_a.push_back(cyc);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            acc[i] = m_ready[i] && req_s;
            if (acc[i]) begin
                busy[i] = 1'b1; k[i] = 0; m_addr[i] = addr_s; acc_cyc[i] = cyc;
            end else if (busy[i]) begin
                k[i]++;
                if (k[i] == pc[i] + wc[i] + 1) m_data[i] = ref_slice();
                if (k[i] > pc[i] + wc[i] + 1) busy[i] = 1'b0;
            end
            m_ready[i] = !busy[i] || (k[i] == pc[i] + wc[i] + 1);
        end
        compare_all();
    endtask

    task automatic set_all(input real v);
        for (int i = 0; i < DW; i++) preout_s[i] = v;
    endtask

    task automatic one_read(input logic [AW-1:0] a);
        req_s = 1'b1; addr_s = a;
        tick();
        req_s = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        int n;
        req_s = 1'b0; addr_s = '0;
        set_all(0.0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        check_eq("reset.ready", if_a.rd_ready, 1'b1);
        check_eq("reset.valid", if_a.rd_valid, 1'b0);
        check_eq("reset.data",  if_a.rd_data, 8'h00);
        check_eq("reset.wl",    wl_a | wl_b, 16'h0000);
        repeat (2) tick();

        // Single read at row 3
        preout_s = '{1.5, 0.0, 1.5, 0.0, 0.9, 0.7, 1.5, 0.0};
        one_read(4'd3);
        check_eq("single.data_a", if_a.rd_data, 8'h55);
        check_eq("single.data_b", if_b.rd_data, 8'h55);

        // Threshold and out-of-range slicing
        set_all(0.8);
        one_read(4'd1);
        check_eq("thr.at_vth", if_a.rd_data, 8'hFF);
        set_all(0.7999);
        one_read(4'd6);
        check_eq("thr.below", if_a.rd_data, 8'h00);
        set_all(1.5);
        preout_s[0] = $bitstoreal(64'h7FF8_0000_0000_0000);
        one_read(4'd7);
        check_eq("thr.nan", if_a.rd_data, 8'hFE);
        set_all(1.5);
        preout_s[0] = 2.0;
        one_read(4'd8);
        check_eq("thr.over", if_a.rd_data, 8'hFE);

        // Back-to-back reads at rows 0 then 15
        preout_s = '{0.0, 1.5, 1.0, 0.2, 1.5, 1.5, 0.0, 0.9};
        valid_cyc_a.delete();
        req_s = 1'b1; addr_s = 4'd0;
        tick();
        check_eq("b2b.acc1", acc[0], 1'b1);
        addr_s = 4'd15;
        n = 0;
        do begin tick(); n++; end while (!acc[0] && n < 20);
        check_eq("b2b.acc2", acc[0], 1'b1);
        req_s = 1'b0;
        repeat (9) tick();
        check_eq("b2b.pulses", valid_cyc_a.size(), 2);
        if (valid_cyc_a.size() >= 2)
            check_eq("b2b.gap", valid_cyc_a[1] - valid_cyc_a[0], 7);

        // Request during PRE must be ignored
        valid_cyc_a.delete();
        set_all(0.0);
        req_s = 1'b1; addr_s = 4'd2;
        tick();
        addr_s = 4'd9;
        tick();
        req_s = 1'b0;
        repeat (8) tick();
        check_eq("ign.pulses", valid_cyc_a.size(), 1);
        check_eq("ign.data", if_a.rd_data, 8'h00);

        // Asynchronous reset in the middle of the wordline phase
        valid_cyc_a.delete();
        set_all(1.5);
        req_s = 1'b1; addr_s = 4'd5;
        tick();
        req_s = 1'b0;
        repeat (3) tick();
        check_eq("rst.wl_before", wl_a, 16'h0020);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst.wl_now",  wl_a, 16'h0000);
        check_eq("rst.pre_now", pre_a, 1'b0);
        check_eq("rst.sae_now", sae_a, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        check_eq("rst.ready", if_a.rd_ready, 1'b1);
        repeat (10) tick();
        check_eq("rst.no_valid", valid_cyc_a.size(), 0);

        // Randomized traffic on both parameterisations
        for (int c = 0; c < 400; c++) begin
            req_s  = ($urandom_range(0, 2) == 0);
            addr_s = AW'($urandom_range(0, NR - 1));
            for (int i = 0; i < DW; i++) begin
                if ($urandom_range(0, 19) == 0)
                    preout_s[i] = $bitstoreal(64'h7FF8_0000_0000_0000);
                else
                    preout_s[i] = $urandom_range(0, 1700) / 1000.0;
            end
            tick();
        end
        req_s = 1'b0;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
